// File: rtl/core_ctrl_fsm_pkg.sv
// Shared types and constants for the RV32 multi-cycle control sequencer.
package core_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } ctrl_state_t;

  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_BR   = 2'b10;

  // funct3 of bne: the ALU reports equality, so bne takes the inverted flag
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_perf_cnt.sv
// Cycle and retired-instruction counters; instantiated only with CORE_PERF_CNT_EN.
module core_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_en,
  input  logic        inst_en,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_en ? cycle_q + 32'd1 : cycle_q;
    instret_d = inst_en ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the RV32 core.
// Optional perf counters are built when CORE_PERF_CNT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for run
// FETCH     | imem request outstanding, ir loads on imem_valid
// DECODE    | decoder and regfile reads settle from ir
// EXECUTE   | ALU evaluates, alu_flag valid at end of cycle
// WRITEBACK | regfile write strobe, pc update
// FAULT     | imem timeout or misaligned target, terminal until reset
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  inst_type_t  inst_type,
  input  logic [1:0]  pc_jmp,
  input  logic [2:0]  wr_en,
  input  logic [31:0] imm,
  input  logic        alu_flag,
  output logic        rf_wr_strobe,
  output logic [1:0]  rf_wr_sel,
  output logic [31:0] pc,
  output logic [2:0]  state_o,
  output logic        fault,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [15:0] TMO_LIMIT = 16'(IMEM_TIMEOUT);

  ctrl_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] tmo_q, tmo_d;

  logic        br_taken;
  logic        take_imm;
  logic [31:0] target;

  // The decoder class does not steer sequencing; kept on the port for the datapath.
  logic inst_type_unused;
  assign inst_type_unused = ^inst_type;

  always_comb begin
    br_taken = alu_flag ^ (ir_q[14:12] == F3_BNE);
    take_imm = (pc_jmp == JMP_JAL) || ((pc_jmp == JMP_BR) && br_taken);
    target   = take_imm ? pc_q + imm : pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      tmo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          tmo_d   = 16'd0;
          state_d = S_DECODE;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if ((IMEM_TIMEOUT != 0) && (tmo_d == TMO_LIMIT)) state_d = S_FAULT;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        // A misaligned target leaves pc on the faulting instruction.
        if (!is_aligned(target)) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = target;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state_q == S_FETCH);
    rf_wr_strobe = 1'b0;
    rf_wr_sel    = 2'b00;
    fault        = (state_q == S_FAULT);
    if (state_q == S_WRITEBACK) begin
      rf_wr_strobe = wr_en[0] && (ir_q[11:7] != 5'd0);
      rf_wr_sel    = wr_en[2:1];
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state_o   = state_q;

`ifdef CORE_PERF_CNT_EN
  logic cycle_en;
  logic inst_en;
  assign cycle_en = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign inst_en  = (state_q == S_WRITEBACK) && is_aligned(target);

  core_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_en    (cycle_en),
    .inst_en     (inst_en),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: instruction stimulus pushes expected
// writeback results, a negedge monitor pops and compares them.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ir;
  inst_type_t  inst_type = INST_R;
  logic [1:0]  pc_jmp = 2'b00;
  logic [2:0]  wr_en = 3'b000;
  logic [31:0] imm = 32'd0;
  logic        alu_flag = 1'b0;
  logic        rf_wr_strobe;
  logic [1:0]  rf_wr_sel;
  logic [31:0] pc;
  logic [2:0]  state_o;
  logic        fault;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        strobe;
    logic [1:0]  sel;
    logic [31:0] pc_next;
    logic [2:0]  st_next;
  } exp_t;

  exp_t sb[$];
  exp_t pend_e;
  logic pend = 1'b0;

  core_ctrl_fsm #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .inst_type    (inst_type),
    .pc_jmp       (pc_jmp),
    .wr_en        (wr_en),
    .imm          (imm),
    .alu_flag     (alu_flag),
    .rf_wr_strobe (rf_wr_strobe),
    .rf_wr_sel    (rf_wr_sel),
    .pc           (pc),
    .state_o      (state_o),
    .fault        (fault),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {17'd0, f3, rd, op};
  endfunction

  // Writeback monitor: strobe/sel in WRITEBACK, pc/state on the following cycle.
  always @(negedge clk) begin
    if (pend) begin
      chk("wb_pc_next", pc, pend_e.pc_next);
      chk("wb_state_next", 32'(state_o), 32'(pend_e.st_next));
      pend = 1'b0;
    end
    if (state_o == 3'd4) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        pend_e = sb.pop_front();
        chk("wb_strobe", 32'(rf_wr_strobe), 32'(pend_e.strobe));
        chk("wb_sel", 32'(rf_wr_sel), 32'(pend_e.sel));
        pend = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cyc", cycle_cnt, 32'd0);
    chk("rst_ret", instret_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_inst(input logic [31:0] instr, input logic [31:0] addr,
                         input logic [1:0] jmp, input logic [2:0] wen,
                         input logic [31:0] imm_i, input logic flag,
                         input int waits, input logic drop_run,
                         input logic e_strobe, input logic [1:0] e_sel,
                         input logic [31:0] e_pc, input logic [2:0] e_st);
    exp_t e;
    e.strobe = e_strobe;
    e.sel = e_sel;
    e.pc_next = e_pc;
    e.st_next = e_st;
    sb.push_back(e);
    for (int i = 0; i < 40; i++) begin
      if (state_o == 3'd1) break;
      @(negedge clk);
    end
    chk("reach_fetch", 32'(state_o), 32'd1);
    chk("fetch_addr", imem_addr, addr);
    for (int w = 0; w < waits; w++) begin
      imem_valid = 1'b0;
      @(negedge clk);
      chk("fetch_wait_req", 32'(imem_req), 32'd1);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("decode_state", 32'(state_o), 32'd2);
    chk("decode_req", 32'(imem_req), 32'd0);
    chk("decode_ir", ir, instr);
    pc_jmp = jmp;
    wr_en = wen;
    imm = imm_i;
    @(negedge clk);
    alu_flag = flag;
    if (drop_run) run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_cyc;
    logic [31:0] exp_ret;
`ifdef CORE_PERF_CNT_EN
    exp_cyc = 32'd12;
    exp_ret = 32'd3;
`else
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
`endif

    // Three back-to-back instructions, run dropped in the last EXECUTE.
    do_reset();
    run = 1'b1;
    do_inst(32'h00500093, 32'd0, JMP_NONE, 3'b001, 32'd5, 1'b0, 0, 1'b0,
            1'b1, 2'd0, 32'd4, 3'd1);
    do_inst(mk(3'b000, 5'd2, 7'h13), 32'd4, JMP_NONE, 3'b001, 32'd1, 1'b0, 0, 1'b0,
            1'b1, 2'd0, 32'd8, 3'd1);
    do_inst(mk(3'b001, 5'd0, 7'h63), 32'd8, JMP_BR, 3'b000, 32'd16, 1'b1, 0, 1'b1,
            1'b0, 2'd0, 32'd12, 3'd0);
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_state", 32'(state_o), 32'd0);
    chk("perf_cycle", cycle_cnt, exp_cyc);
    chk("perf_instret", instret_cnt, exp_ret);

    // Asynchronous reset in the middle of a stalled fetch.
    run = 1'b1;
    @(negedge clk);
    chk("mid_fetch_state", 32'(state_o), 32'd1);
    chk("mid_fetch_addr", imem_addr, 32'd12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_ir", ir, 32'd0);

    // Wrap-around, branches, JAL, x0 suppression, misaligned target.
    do_reset();
    run = 1'b1;
    do_inst(mk(3'b000, 5'd0, 7'h6F), 32'd0, JMP_JAL, 3'b101, 32'hFFFF_FFFC, 1'b0, 0, 1'b0,
            1'b0, 2'd2, 32'hFFFF_FFFC, 3'd1);
    do_inst(mk(3'b000, 5'd1, 7'h13), 32'hFFFF_FFFC, JMP_NONE, 3'b001, 32'd5, 1'b0, 3, 1'b0,
            1'b1, 2'd0, 32'd0, 3'd1);
    do_inst(mk(3'b000, 5'd2, 7'h13), 32'd0, JMP_NONE, 3'b001, 32'd1, 1'b0, 0, 1'b0,
            1'b1, 2'd0, 32'd4, 3'd1);
    do_inst(mk(3'b000, 5'd3, 7'h13), 32'd4, JMP_NONE, 3'b011, 32'd1, 1'b0, 1, 1'b0,
            1'b1, 2'd1, 32'd8, 3'd1);
    do_inst(mk(3'b001, 5'd0, 7'h63), 32'd8, JMP_BR, 3'b000, 32'd16, 1'b0, 0, 1'b0,
            1'b0, 2'd0, 32'd24, 3'd1);
    do_inst(mk(3'b000, 5'd0, 7'h63), 32'd24, JMP_BR, 3'b000, 32'd100, 1'b0, 0, 1'b0,
            1'b0, 2'd0, 32'd28, 3'd1);
    do_inst(mk(3'b000, 5'd4, 7'h13), 32'd28, JMP_NONE, 3'b001, 32'd2, 1'b0, 0, 1'b0,
            1'b1, 2'd0, 32'd32, 3'd1);
    do_inst(mk(3'b000, 5'd1, 7'h6F), 32'd32, JMP_JAL, 3'b101, 32'hFFFF_FFF8, 1'b0, 0, 1'b0,
            1'b1, 2'd2, 32'd24, 3'd1);
    do_inst(mk(3'b000, 5'd0, 7'h6F), 32'd24, JMP_JAL, 3'b101, 32'hFFFF_FFF8, 1'b0, 0, 1'b0,
            1'b0, 2'd2, 32'd16, 3'd1);
    do_inst(mk(3'b000, 5'd1, 7'h6F), 32'd16, JMP_JAL, 3'b101, 32'd2, 1'b0, 0, 1'b0,
            1'b1, 2'd2, 32'd16, 3'd5);
    @(negedge clk);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_valid = 1'b0;
    chk("mis_hold_state", 32'(state_o), 32'd5);
    chk("mis_hold_ir", ir, mk(3'b000, 5'd1, 7'h6F));
    chk("mis_hold_pc", pc, 32'd16);

    // imem never answers: FAULT after exactly 16 FETCH cycles.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("tmo_fetch", 32'(state_o), 32'd1);
      @(negedge clk);
    end
    chk("tmo_state", 32'(state_o), 32'd5);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_req", 32'(imem_req), 32'd0);
    chk("tmo_pc", pc, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("tmo_ignore_ir", ir, 32'd0);
    chk("tmo_ignore_state", 32'(state_o), 32'd5);
    chk("tmo_strobe", 32'(rf_wr_strobe), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
- Multi-cycle sequencer for the single-issue RV32 core. Fetches from instruction memory over a req/valid handshake and latches the instruction register that feeds the decoder.
- Steps the decode, execute and writeback phases, issues register-file write strobes, and computes the next PC from the decoder's jump/branch class and the ALU condition flag.
- Sits between imem, the decoder, the ALU and the register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, FETCH cycles without imem_valid before a fault is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 allows instruction execution
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_valid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, drives the decoder
- inst_type  in  inst_type_t  decoder instruction class
- pc_jmp  in  2  decoder jump class: 01 = JAL, 10 = branch, 00 = sequential
- wr_en  in  3  decoder write control: [0] = write, [2:1] = writeback source
- imm  in  32  decoder immediate, signed
- alu_flag  in  1  ALU compare result (EQL/LT/GE)
- rf_wr_strobe  out  1  one-cycle register-file write enable
- rf_wr_sel  out  2  writeback source select
- pc  out  32  current PC
- state_o  out  3  current state, for debug
- fault  out  1  sticky fault
- cycle_cnt  out  32  see Optional Feature
- instret_cnt  out  32  see Optional Feature

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FAULT. Encoding is fixed: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, FAULT=5.
- Reset (async, any state) forces:
  - state=IDLE, pc=RESET_PC, ir=0
  - imem_req=0, rf_wr_strobe=0, rf_wr_sel=0, fault=0
  - timeout counter = 0, both perf counters = 0
- IDLE:
  - All strobes are 0.
  - run=1 → FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1 → ir<=imem_rdata, go to DECODE, timeout counter cleared.
  - imem_valid=0 → counter increments. When the counter reaches IMEM_TIMEOUT (nonzero) → FAULT.
  - imem_req drops in the cycle after valid is accepted.
- DECODE: one cycle. Decoder outputs and register-file reads settle from ir; no side effects.
- EXECUTE: one cycle. The ALU evaluates; alu_flag is valid by the end of the cycle.
- WRITEBACK: one cycle.
  - rf_wr_strobe = wr_en[0] && (ir[11:7] != 0). Writes to x0 are suppressed.
  - rf_wr_sel = wr_en[2:1].
  - Branch taken: taken = alu_flag XOR (ir[14:12]==3'b001), i.e. bne inverts the EQL result.
  - Next PC:
    - pc_jmp==01 → pc+imm
    - pc_jmp==10 && taken → pc+imm
    - otherwise → pc+4
    - All sums are 32-bit modulo with wrap-around (pc=32'hFFFF_FFFC with +4 gives 0).
  - Next state: run=1 → FETCH, else IDLE.
- Misaligned target: a computed target with [1:0]!=0 → FAULT.
  - pc is not updated.
  - The register write in that same WRITEBACK cycle still occurs.
- run deasserted mid-instruction: the current instruction completes through WRITEBACK, then the FSM enters IDLE.
- FAULT:
  - fault=1, all strobes 0. Terminal until reset.
  - An imem_valid arriving in FAULT is ignored.
- Throughput: 4 cycles per instruction minimum (valid in the first FETCH cycle); each imem wait cycle adds 1.
- The decoder's default-to-R behaviour is not checked here; illegal opcodes execute as R-type.

Optional Feature:
- Macro CORE_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle the state is not IDLE or FAULT.
  - instret_cnt increments once per WRITEBACK that does not fault.
  - Both are 32-bit wrapping counters, cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Add to TypesPkg:
  - ctrl_state_t enum with the encoding above
  - PC_STEP = 4
  - RESET_PC_DEFAULT
  - JMP_NONE/JMP_JAL/JMP_BR constants for pc_jmp
- Sub-module core_perf_cnt holds both counters. It is instantiated only under CORE_PERF_CNT_EN.

Test Plan:
1. Reset then run=1, imem returns 32'h00500093 (addi x1,x0,5) with valid in the first FETCH cycle → rf_wr_strobe=1 in cycle 4 with rf_wr_sel=0, pc 0→4, back in FETCH in cycle 5.
2. bne with alu_flag=1 (operands equal), imm=16, pc=8 → branch not taken, pc=12. Repeat with alu_flag=0 → pc=24. No rf_wr_strobe in either case.
3. JAL with rd=x1, imm=-8, pc=32 → pc=24, rf_wr_strobe=1, rf_wr_sel=2. The same JAL with rd=x0 → rf_wr_strobe=0.
4. imem_valid held 0 with IMEM_TIMEOUT=16 → FAULT entered after 16 FETCH cycles, fault=1, imem_req=0, pc unchanged. Later imem_valid pulses are ignored.
5. run dropped during EXECUTE → WRITEBACK completes, then IDLE with imem_req=0. rst_n asserted mid-FETCH → outputs go to reset values immediately (asynchronously), pc=RESET_PC.
6. Under CORE_PERF_CNT_EN, 3 instructions with zero imem wait → instret_cnt=3, cycle_cnt=12. Without the macro → both ports read 0.
